// File: rtl/ctrl_redirect_unit_pkg.sv
// rtl/ctrl_redirect_unit_pkg.sv - shared flag map, FSM encoding, update-record layout and ROB age helper
package ctrl_redirect_unit_pkg;

    localparam int DEF_SIZE_PC      = 32;
    localparam int DEF_SIZE_ROB_LOG = 7;
    localparam int DEF_UPD_DEPTH    = 4;

    localparam int FLAG_CTRL = 7;
    localparam int FLAG_COND = 5;
    localparam int FLAG_LINK = 4;
    localparam int FLAG_EXEC = 2;
    localparam int FLAG_MISP = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_RECOVER  = 2'd2
    } redir_state_t;

    // Update record packing, LSB first: is_cond, dir, target, pc.
    localparam int REC_COND_BIT = 0;
    localparam int REC_DIR_BIT  = 1;
    localparam int REC_TGT_LSB  = 2;

    function automatic int upd_rec_w(input int pc_w);
        return 2 * pc_w + 2;
    endfunction

    // Distance from the ROB head, modulo 2^w; a smaller result means an older op.
    function automatic logic [31:0] rob_age(input logic [31:0] id, input logic [31:0] head, input int w);
        return (id - head) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/ctrl_upd_fifo.sv
// rtl/ctrl_upd_fifo.sv - synchronous FIFO with drop-on-full and same-cycle push/pop
module ctrl_upd_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign not_empty = !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            drop <= push && full && !do_pop;
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_redirect_unit.sv
// rtl/ctrl_redirect_unit.sv - mispredict redirect/recovery sequencer and predictor update queue
module ctrl_redirect_unit
    import ctrl_redirect_unit_pkg::*;
#(
    parameter int SIZE_PC      = DEF_SIZE_PC,
    parameter int SIZE_ROB_LOG = DEF_SIZE_ROB_LOG,
    parameter int UPD_DEPTH    = DEF_UPD_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    exe_valid_i,
    input  logic [SIZE_PC-1:0]      exe_pc_i,
    input  logic [SIZE_PC-1:0]      exe_nextPC_i,
    input  logic                    exe_dir_i,
    input  logic [7:0]              exe_flags_i,
    input  logic [SIZE_ROB_LOG-1:0] exe_robId_i,
    input  logic [SIZE_ROB_LOG-1:0] rob_head_i,
    output logic                    redirect_valid_o,
    output logic [SIZE_PC-1:0]      redirect_pc_o,
    output logic [SIZE_ROB_LOG-1:0] redirect_robId_o,
    input  logic                    fetch_ready_i,
    input  logic                    recover_done_i,
    output logic                    upd_valid_o,
    output logic [SIZE_PC-1:0]      upd_pc_o,
    output logic [SIZE_PC-1:0]      upd_target_o,
    output logic                    upd_dir_o,
    output logic                    upd_isCond_o,
    input  logic                    upd_ready_i,
    output logic                    upd_drop_o,
    output logic [15:0]             redirect_cnt_o
);
    localparam int REC_W = upd_rec_w(SIZE_PC);

    redir_state_t              state, state_nxt;
    logic [SIZE_PC-1:0]        lat_pc, lat_pc_nxt;
    logic [SIZE_ROB_LOG-1:0]   lat_id, lat_id_nxt;
    logic                      cnt_inc;
    logic                      push;
    logic                      considered;
    logic                      mispred;
    logic                      is_older;
    logic [31:0]               age_exe;
    logic [31:0]               age_lat;
    logic [REC_W-1:0]          push_rec;
    logic [REC_W-1:0]          head_rec;
    logic                      unused_flags;

    assign considered = exe_valid_i && exe_flags_i[FLAG_CTRL] && exe_flags_i[FLAG_EXEC];
    assign mispred    = considered && exe_flags_i[FLAG_MISP];

    assign age_exe  = rob_age(32'(exe_robId_i), 32'(rob_head_i), SIZE_ROB_LOG);
    assign age_lat  = rob_age(32'(lat_id), 32'(rob_head_i), SIZE_ROB_LOG);
    // Strictly older only: an equal id is the already-latched op and is ignored.
    assign is_older = (age_exe < age_lat);

    assign unused_flags = &{1'b0, exe_flags_i[6], exe_flags_i[FLAG_LINK], exe_flags_i[3], exe_flags_i[1]};

    always_comb begin
        state_nxt  = state;
        lat_pc_nxt = lat_pc;
        lat_id_nxt = lat_id;
        cnt_inc    = 1'b0;
        push       = considered;
        case (state)
            ST_IDLE: begin
                if (mispred) begin
                    lat_pc_nxt = exe_nextPC_i;
                    lat_id_nxt = exe_robId_i;
                    state_nxt  = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                push = considered && is_older;
                if (mispred && is_older) begin
                    lat_pc_nxt = exe_nextPC_i;
                    lat_id_nxt = exe_robId_i;
                end else if (fetch_ready_i) begin
                    state_nxt = ST_RECOVER;
                    cnt_inc   = 1'b1;
                end
            end
            ST_RECOVER: begin
                push = considered && is_older;
                if (mispred && is_older) begin
                    lat_pc_nxt = exe_nextPC_i;
                    lat_id_nxt = exe_robId_i;
                    state_nxt  = ST_REDIRECT;
                end else if (recover_done_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            lat_pc         <= '0;
            lat_id         <= '0;
            redirect_cnt_o <= '0;
        end else begin
            state  <= state_nxt;
            lat_pc <= lat_pc_nxt;
            lat_id <= lat_id_nxt;
            if (cnt_inc) begin
                redirect_cnt_o <= redirect_cnt_o + 16'd1;
            end
        end
    end

    assign redirect_valid_o = (state == ST_REDIRECT);
    assign redirect_pc_o    = lat_pc;
    assign redirect_robId_o = lat_id;

    assign push_rec = {exe_pc_i, exe_nextPC_i, exe_dir_i, exe_flags_i[FLAG_COND]};

    ctrl_upd_fifo #(
        .WIDTH (REC_W),
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_rec),
        .pop       (upd_ready_i),
        .head_data (head_rec),
        .not_empty (upd_valid_o),
        .drop      (upd_drop_o)
    );

    assign upd_isCond_o = head_rec[REC_COND_BIT];
    assign upd_dir_o    = head_rec[REC_DIR_BIT];
    assign upd_target_o = head_rec[REC_TGT_LSB +: SIZE_PC];
    assign upd_pc_o     = head_rec[REC_TGT_LSB + SIZE_PC +: SIZE_PC];

endmodule

// File: tb/tb_ctrl_redirect_unit.sv
// tb/tb_ctrl_redirect_unit.sv - directed self-checking bench for ctrl_redirect_unit
module tb_ctrl_redirect_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_valid_i;
    logic [31:0] exe_pc_i;
    logic [31:0] exe_nextPC_i;
    logic        exe_dir_i;
    logic [7:0]  exe_flags_i;
    logic [6:0]  exe_robId_i;
    logic [6:0]  rob_head_i;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [6:0]  redirect_robId_o;
    logic        fetch_ready_i;
    logic        recover_done_i;
    logic        upd_valid_o;
    logic [31:0] upd_pc_o;
    logic [31:0] upd_target_o;
    logic        upd_dir_o;
    logic        upd_isCond_o;
    logic        upd_ready_i;
    logic        upd_drop_o;
    logic [15:0] redirect_cnt_o;

    int vectors = 0;
    int errors  = 0;

    localparam logic [7:0] F_MISP = 8'hA5;
    localparam logic [7:0] F_OK   = 8'hA4;

    always #5 clk = ~clk;

    ctrl_redirect_unit dut (
        .clk              (clk),
        .reset            (reset),
        .exe_valid_i      (exe_valid_i),
        .exe_pc_i         (exe_pc_i),
        .exe_nextPC_i     (exe_nextPC_i),
        .exe_dir_i        (exe_dir_i),
        .exe_flags_i      (exe_flags_i),
        .exe_robId_i      (exe_robId_i),
        .rob_head_i       (rob_head_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_robId_o (redirect_robId_o),
        .fetch_ready_i    (fetch_ready_i),
        .recover_done_i   (recover_done_i),
        .upd_valid_o      (upd_valid_o),
        .upd_pc_o         (upd_pc_o),
        .upd_target_o     (upd_target_o),
        .upd_dir_o        (upd_dir_o),
        .upd_isCond_o     (upd_isCond_o),
        .upd_ready_i      (upd_ready_i),
        .upd_drop_o       (upd_drop_o),
        .redirect_cnt_o   (redirect_cnt_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_exe(input logic [31:0] pc, input logic [31:0] npc, input logic dir,
                           input logic [7:0] fl, input logic [6:0] id);
        exe_valid_i  = 1'b1;
        exe_pc_i     = pc;
        exe_nextPC_i = npc;
        exe_dir_i    = dir;
        exe_flags_i  = fl;
        exe_robId_i  = id;
    endtask

    task automatic clr_exe;
        exe_valid_i = 1'b0;
        exe_flags_i = 8'h00;
    endtask

    task automatic do_reset;
        reset          = 1'b1;
        clr_exe();
        exe_pc_i       = '0;
        exe_nextPC_i   = '0;
        exe_dir_i      = 1'b0;
        exe_robId_i    = '0;
        rob_head_i     = '0;
        fetch_ready_i  = 1'b0;
        recover_done_i = 1'b0;
        upd_ready_i    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        vectors++;
        if ({redirect_valid_o, redirect_pc_o, redirect_robId_o, upd_valid_o, upd_pc_o,
             upd_target_o, upd_dir_o, upd_isCond_o, upd_drop_o, redirect_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rv=%0b rpc=%h cnt=%0d uv=%0b exp all zero",
                     redirect_valid_o, redirect_pc_o, redirect_cnt_o, upd_valid_o);
        end
    endtask

    task automatic test_single_redirect;
        do_reset();
        set_exe(32'h100, 32'h400, 1'b1, F_MISP, 7'd5);
        tick();
        clr_exe();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h400 || redirect_robId_o !== 7'd5) begin
                errors++;
                $display("FAIL single_hold[%0d] got v=%0b pc=%h id=%0d exp v=1 pc=400 id=5",
                         i, redirect_valid_o, redirect_pc_o, redirect_robId_o);
            end
            tick();
        end
        vectors++;
        if (upd_valid_o !== 1'b1 || upd_pc_o !== 32'h100 || upd_target_o !== 32'h400 ||
            upd_dir_o !== 1'b1 || upd_isCond_o !== 1'b1) begin
            errors++;
            $display("FAIL single_upd_rec got v=%0b pc=%h tgt=%h d=%0b c=%0b exp 1 100 400 1 1",
                     upd_valid_o, upd_pc_o, upd_target_o, upd_dir_o, upd_isCond_o);
        end
        fetch_ready_i = 1'b1;
        upd_ready_i   = 1'b1;
        tick();
        fetch_ready_i = 1'b0;
        upd_ready_i   = 1'b0;
        vectors++;
        if (redirect_valid_o !== 1'b0 || redirect_cnt_o !== 16'd1 || upd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_accept got v=%0b cnt=%0d uv=%0b exp v=0 cnt=1 uv=0",
                     redirect_valid_o, redirect_cnt_o, upd_valid_o);
        end
        recover_done_i = 1'b1;
        tick();
        recover_done_i = 1'b0;
        set_exe(32'h104, 32'h500, 1'b0, F_MISP, 7'd6);
        tick();
        clr_exe();
        vectors++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h500) begin
            errors++;
            $display("FAIL single_back_to_idle got v=%0b pc=%h exp v=1 pc=500",
                     redirect_valid_o, redirect_pc_o);
        end
    endtask

    task automatic test_older_replace;
        do_reset();
        rob_head_i = 7'd120;
        set_exe(32'h20, 32'hA00, 1'b1, F_MISP, 7'd2);
        tick();
        set_exe(32'h30, 32'hB00, 1'b0, F_MISP, 7'd125);
        tick();
        clr_exe();
        vectors++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'hB00 || redirect_robId_o !== 7'd125) begin
            errors++;
            $display("FAIL older_replace got v=%0b pc=%h id=%0d exp v=1 pc=b00 id=125",
                     redirect_valid_o, redirect_pc_o, redirect_robId_o);
        end
        fetch_ready_i = 1'b1;
        tick();
        fetch_ready_i = 1'b0;
        vectors++;
        if (redirect_valid_o !== 1'b0 || redirect_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL older_count got v=%0b cnt=%0d exp v=0 cnt=1", redirect_valid_o, redirect_cnt_o);
        end
        vectors++;
        if (upd_valid_o !== 1'b1 || upd_pc_o !== 32'h20 || upd_target_o !== 32'hA00) begin
            errors++;
            $display("FAIL older_upd0 got v=%0b pc=%h tgt=%h exp 1 20 a00", upd_valid_o, upd_pc_o, upd_target_o);
        end
        upd_ready_i = 1'b1;
        tick();
        vectors++;
        if (upd_valid_o !== 1'b1 || upd_pc_o !== 32'h30 || upd_dir_o !== 1'b0) begin
            errors++;
            $display("FAIL older_upd1 got v=%0b pc=%h d=%0b exp 1 30 0", upd_valid_o, upd_pc_o, upd_dir_o);
        end
        tick();
        upd_ready_i = 1'b0;
    endtask

    task automatic test_younger_ignored;
        do_reset();
        rob_head_i = 7'd120;
        set_exe(32'h30, 32'hB00, 1'b0, F_MISP, 7'd125);
        tick();
        set_exe(32'h20, 32'hA00, 1'b1, F_MISP, 7'd2);
        tick();
        clr_exe();
        vectors++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'hB00 || redirect_robId_o !== 7'd125) begin
            errors++;
            $display("FAIL younger_kept got v=%0b pc=%h id=%0d exp v=1 pc=b00 id=125",
                     redirect_valid_o, redirect_pc_o, redirect_robId_o);
        end
        vectors++;
        if (upd_valid_o !== 1'b1 || upd_pc_o !== 32'h30) begin
            errors++;
            $display("FAIL younger_upd0 got v=%0b pc=%h exp 1 30", upd_valid_o, upd_pc_o);
        end
        upd_ready_i = 1'b1;
        tick();
        upd_ready_i = 1'b0;
        vectors++;
        if (upd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL younger_no_record got uv=%0b exp 0", upd_valid_o);
        end
    endtask

    task automatic test_recover_priority;
        do_reset();
        set_exe(32'h40, 32'hC00, 1'b1, F_MISP, 7'd10);
        tick();
        clr_exe();
        fetch_ready_i = 1'b1;
        tick();
        fetch_ready_i = 1'b0;
        set_exe(32'h44, 32'hD00, 1'b1, F_MISP, 7'd3);
        recover_done_i = 1'b1;
        tick();
        clr_exe();
        recover_done_i = 1'b0;
        vectors++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'hD00 || redirect_robId_o !== 7'd3 ||
            redirect_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL recover_priority got v=%0b pc=%h id=%0d cnt=%0d exp 1 d00 3 1",
                     redirect_valid_o, redirect_pc_o, redirect_robId_o, redirect_cnt_o);
        end
        fetch_ready_i = 1'b1;
        tick();
        fetch_ready_i = 1'b0;
        vectors++;
        if (redirect_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL recover_count got cnt=%0d exp 2", redirect_cnt_o);
        end
    endtask

    task automatic test_fifo_full;
        logic [31:0] pc_exp;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_exe(32'h10 * (i + 1), 32'h1000 + i, i[0], F_OK, 7'(i));
            tick();
            if (i == 3) begin
                vectors++;
                if (upd_drop_o !== 1'b0) begin
                    errors++;
                    $display("FAIL fifo_no_early_drop got %0b exp 0", upd_drop_o);
                end
            end
        end
        clr_exe();
        vectors++;
        if (upd_drop_o !== 1'b1) begin
            errors++;
            $display("FAIL fifo_drop_pulse got %0b exp 1", upd_drop_o);
        end
        tick();
        vectors++;
        if (upd_drop_o !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drop_once got %0b exp 0", upd_drop_o);
        end
        for (int i = 0; i < 4; i++) begin
            pc_exp = 32'h10 * (i + 1);
            vectors++;
            if (upd_valid_o !== 1'b1 || upd_pc_o !== pc_exp || upd_target_o !== 32'h1000 + i ||
                upd_dir_o !== i[0] || upd_isCond_o !== 1'b1) begin
                errors++;
                $display("FAIL fifo_order[%0d] got v=%0b pc=%h tgt=%h d=%0b c=%0b exp pc=%h",
                         i, upd_valid_o, upd_pc_o, upd_target_o, upd_dir_o, upd_isCond_o, pc_exp);
            end
            upd_ready_i = 1'b1;
            tick();
            upd_ready_i = 1'b0;
        end
        vectors++;
        if (upd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fifo_empty got uv=%0b exp 0", upd_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            set_exe(32'h60 + 32'h10 * i, 32'h2000 + i, 1'b0, F_OK, 7'(i));
            tick();
        end
        set_exe(32'hA0, 32'h2004, 1'b1, F_OK, 7'd4);
        upd_ready_i = 1'b1;
        tick();
        clr_exe();
        upd_ready_i = 1'b0;
        vectors++;
        if (upd_drop_o !== 1'b0 || upd_pc_o !== 32'h70) begin
            errors++;
            $display("FAIL fifo_full_push_pop got drop=%0b head=%h exp drop=0 head=70", upd_drop_o, upd_pc_o);
        end
        for (int i = 0; i < 4; i++) begin
            pc_exp = 32'h70 + 32'h10 * i;
            vectors++;
            if (upd_valid_o !== 1'b1 || upd_pc_o !== pc_exp) begin
                errors++;
                $display("FAIL fifo_refill[%0d] got v=%0b pc=%h exp pc=%h", i, upd_valid_o, upd_pc_o, pc_exp);
            end
            upd_ready_i = 1'b1;
            tick();
            upd_ready_i = 1'b0;
        end
        vectors++;
        if (upd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fifo_refill_empty got uv=%0b exp 0", upd_valid_o);
        end
    endtask

    task automatic test_reset_mid_op;
        do_reset();
        set_exe(32'h200, 32'h800, 1'b1, F_MISP, 7'd5);
        tick();
        clr_exe();
        fetch_ready_i = 1'b1;
        tick();
        fetch_ready_i  = 1'b0;
        recover_done_i = 1'b1;
        tick();
        recover_done_i = 1'b0;
        set_exe(32'h300, 32'h900, 1'b0, F_MISP, 7'd6);
        tick();
        clr_exe();
        vectors++;
        if (redirect_valid_o !== 1'b1 || redirect_cnt_o !== 16'd1 || upd_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup got v=%0b cnt=%0d uv=%0b exp 1 1 1",
                     redirect_valid_o, redirect_cnt_o, upd_valid_o);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({redirect_valid_o, redirect_pc_o, redirect_robId_o, upd_valid_o, upd_pc_o,
             upd_target_o, upd_dir_o, upd_isCond_o, upd_drop_o, redirect_cnt_o} !== '0) begin
            errors++;
            $display("FAIL midreset_clear got rv=%0b rpc=%h cnt=%0d uv=%0b upc=%h exp all zero",
                     redirect_valid_o, redirect_pc_o, redirect_cnt_o, upd_valid_o, upd_pc_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_redirect();
        test_older_replace();
        test_younger_ignored();
        test_recover_priority();
        test_fifo_full();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
